writeback_stage: RTL and testbench

//  Write-back end of the Y86 pipeline: holds the W pipeline register (M->W), drives the register-file

---
 rtl/writeback_stage.sv | 189 ++++++++++++++++++
 tb/tb_writeback_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Write-back end of the Y86 pipeline. Holds the W pipeline register (M->W),
// presents the register-file write ports (E and M), exports the W destination
// registers as forwarding taps for decode, and tracks architectural CPU status.
// The first non-AOK status to reach W freezes the machine until reset.
//
// Optional feature:
//   WB_RETIRE_CNT_EN  when defined, a 64-bit retired-instruction counter is
//                     built and driven on retire_cnt_o; otherwise
//                     retire_cnt_o is tied to zero and no counter flops exist.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous reset, active-high
//   W_stall_i     hold W register
//   W_bubble_i    load NOP bubble into W register
//   m_stat_i      memory-stage status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//   M_icode_i     memory-stage icode
//   M_dstE_i      memory-stage E destination
//   M_valE_i      memory-stage E value
//   M_dstM_i      memory-stage M destination
//   m_valM_i      memory read data
//   W_icode_o     registered icode
//   W_dstE_o      registered E destination (forwarding tap / write address)
//   W_valE_o      registered E value (write data)
//   W_dstM_o      registered M destination (forwarding tap / write address)
//   W_valM_o      registered M value (write data)
//   wr_e_en_o     register-file E-port write enable
//   wr_m_en_o     register-file M-port write enable
//   stat_o        architectural CPU status
//   halted_o      machine frozen
//   retire_cnt_o  retired-instruction count
// -----------------------------------------------------------------------------
module writeback_stage #(
  parameter int          DW        = 64,
  parameter logic [3:0]  RNONE     = 4'hf,
  parameter logic [3:0]  NOP_ICODE = 4'h1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          W_stall_i,
  input  logic          W_bubble_i,
  input  logic [3:0]    m_stat_i,
  input  logic [3:0]    M_icode_i,
  input  logic [3:0]    M_dstE_i,
  input  logic [DW-1:0] M_valE_i,
  input  logic [3:0]    M_dstM_i,
  input  logic [DW-1:0] m_valM_i,
  output logic [3:0]    W_icode_o,
  output logic [3:0]    W_dstE_o,
  output logic [DW-1:0] W_valE_o,
  output logic [3:0]    W_dstM_o,
  output logic [DW-1:0] W_valM_o,
  output logic          wr_e_en_o,
  output logic          wr_m_en_o,
  output logic [3:0]    stat_o,
  output logic          halted_o,
  output logic [63:0]   retire_cnt_o
);

  localparam logic [3:0] STAT_AOK = 4'd1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } wb_state_t;

  // W pipeline register
  logic [3:0]    icode_reg;
  logic [3:0]    dst_e_reg;
  logic [DW-1:0] val_e_reg;
  logic [3:0]    dst_m_reg;
  logic [DW-1:0] val_m_reg;
  logic [3:0]    stat_reg;

  // Freeze control
  wb_state_t     state_reg;
  logic [3:0]    halt_stat_reg;

  // Qualifiers shared by the write enables and the retire counter
  logic running;
  logic w_aok;
  logic dst_e_valid;
  logic dst_m_valid;
  logic dst_collide;

  assign running     = (state_reg == ST_RUN);
  assign w_aok       = (stat_reg == STAT_AOK);
  assign dst_e_valid = (dst_e_reg != RNONE);
  assign dst_m_valid = (dst_m_reg != RNONE);
  // Same register targeted by both ports (e.g. popq %rsp): the loaded
  // value must win, so the E port stands down.
  assign dst_collide = dst_m_valid && (dst_e_reg == dst_m_reg);

  // ---------------------------------------------------------------------------
  // W register and freeze FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      icode_reg     <= NOP_ICODE;
      dst_e_reg     <= RNONE;
      val_e_reg     <= '0;
      dst_m_reg     <= RNONE;
      val_m_reg     <= '0;
      stat_reg      <= STAT_AOK;
      state_reg     <= ST_RUN;
      halt_stat_reg <= STAT_AOK;
    end else begin
      case (state_reg)
        ST_RUN: begin
          // A faulting status sitting in W this cycle freezes the machine at
          // the next edge; the status is captured so it stays visible.
          if (!w_aok) begin
            state_reg     <= ST_HALT;
            halt_stat_reg <= stat_reg;
          end

          if (W_stall_i) begin
            // hold; stall outranks a simultaneous bubble
          end else if (W_bubble_i) begin
            icode_reg <= NOP_ICODE;
            dst_e_reg <= RNONE;
            val_e_reg <= '0;
            dst_m_reg <= RNONE;
            val_m_reg <= '0;
            stat_reg  <= STAT_AOK;
          end else begin
            icode_reg <= M_icode_i;
            dst_e_reg <= M_dstE_i;
            val_e_reg <= M_valE_i;
            dst_m_reg <= M_dstM_i;
            val_m_reg <= m_valM_i;
            stat_reg  <= m_stat_i;
          end
        end
        ST_HALT: begin
          // frozen: only reset leaves this state
        end
        default: begin
          state_reg <= ST_HALT;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register-file write port and status outputs
  // ---------------------------------------------------------------------------
  assign W_icode_o = icode_reg;
  assign W_dstE_o  = dst_e_reg;
  assign W_valE_o  = val_e_reg;
  assign W_dstM_o  = dst_m_reg;
  assign W_valM_o  = val_m_reg;

  // A faulting instruction never commits its destinations; neither does
  // anything once the machine is frozen.
  assign wr_e_en_o = running && w_aok && dst_e_valid && !dst_collide;
  assign wr_m_en_o = running && w_aok && dst_m_valid;

  assign stat_o    = running ? stat_reg : halt_stat_reg;
  assign halted_o  = !running;

  // ---------------------------------------------------------------------------
  // Retired-instruction counter
  // ---------------------------------------------------------------------------
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_reg;
  logic        retire_now;

  // An instruction retires on the edge it leaves W: it must be real (not a
  // bubble), healthy, and not being held by a stall.
  assign retire_now = running && w_aok && (icode_reg != NOP_ICODE) && !W_stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retire_cnt_reg <= '0;
    end else if (retire_now) begin
      retire_cnt_reg <= retire_cnt_reg + 64'd1;  // wraps naturally
    end
  end

  assign retire_cnt_o = retire_cnt_reg;
`else
  assign retire_cnt_o = 64'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  localparam int DW = 64;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          W_stall_i;
  logic          W_bubble_i;
  logic [3:0]    m_stat_i;
  logic [3:0]    M_icode_i;
  logic [3:0]    M_dstE_i;
  logic [DW-1:0] M_valE_i;
  logic [3:0]    M_dstM_i;
  logic [DW-1:0] m_valM_i;
  logic [3:0]    W_icode_o;
  logic [3:0]    W_dstE_o;
  logic [DW-1:0] W_valE_o;
  logic [3:0]    W_dstM_o;
  logic [DW-1:0] W_valM_o;
  logic          wr_e_en_o;
  logic          wr_m_en_o;
  logic [3:0]    stat_o;
  logic          halted_o;
  logic [63:0]   retire_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  // Register file fed by the DUT write port (E first, M overrides).
  logic [63:0] rf [0:15];

  writeback_stage dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .W_stall_i    (W_stall_i),
    .W_bubble_i   (W_bubble_i),
    .m_stat_i     (m_stat_i),
    .M_icode_i    (M_icode_i),
    .M_dstE_i     (M_dstE_i),
    .M_valE_i     (M_valE_i),
    .M_dstM_i     (M_dstM_i),
    .m_valM_i     (m_valM_i),
    .W_icode_o    (W_icode_o),
    .W_dstE_o     (W_dstE_o),
    .W_valE_o     (W_valE_o),
    .W_dstM_o     (W_dstM_o),
    .W_valM_o     (W_valM_o),
    .wr_e_en_o    (wr_e_en_o),
    .wr_m_en_o    (wr_m_en_o),
    .stat_o       (stat_o),
    .halted_o     (halted_o),
    .retire_cnt_o (retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 64'd0;
  end

  always @(posedge clk_i) begin
    if (wr_e_en_o) rf[W_dstE_o] <= W_valE_o;
    if (wr_m_en_o) rf[W_dstM_o] <= W_valM_o;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_m(input logic [3:0] stat, input logic [3:0] icode,
                         input logic [3:0] dste, input logic [63:0] vale,
                         input logic [3:0] dstm, input logic [63:0] valm);
    m_stat_i  = stat;
    M_icode_i = icode;
    M_dstE_i  = dste;
    M_valE_i  = vale;
    M_dstM_i  = dstm;
    m_valM_i  = valm;
  endtask

  logic [63:0] exp_cnt;

  initial begin
    rst_i      = 1'b1;
    W_stall_i  = 1'b0;
    W_bubble_i = 1'b0;
    drive_m(4'd1, 4'h1, 4'hf, 64'd0, 4'hf, 64'd0);

    // 1: reset
    repeat (3) step();
    check("rst_icode", W_icode_o, 64'h1);
    check("rst_dstE", W_dstE_o, 64'hf);
    check("rst_dstM", W_dstM_o, 64'hf);
    check("rst_wr_e", wr_e_en_o, 64'd0);
    check("rst_wr_m", wr_m_en_o, 64'd0);
    check("rst_stat", stat_o, 64'd1);
    check("rst_halted", halted_o, 64'd0);
    check("rst_cnt", retire_cnt_o, 64'd0);
    rst_i = 1'b0;

    // 2: irmovq to R3
    drive_m(4'd1, 4'h3, 4'h3, 64'h55, 4'hf, 64'd0);
    step();
    check("e_dstE", W_dstE_o, 64'h3);
    check("e_valE", W_valE_o, 64'h55);
    check("e_wr_e", wr_e_en_o, 64'd1);
    check("e_wr_m", wr_m_en_o, 64'd0);
    drive_m(4'd1, 4'h1, 4'hf, 64'd0, 4'hf, 64'd0);
    step();
    check("e_R3", rf[3], 64'h55);
    check("nop_wr_e", wr_e_en_o, 64'd0);

    // 3: popq-style collision on R4
    drive_m(4'd1, 4'hb, 4'h4, 64'h10, 4'h4, 64'h20);
    step();
    check("col_wr_m", wr_m_en_o, 64'd1);
    check("col_wr_e", wr_e_en_o, 64'd0);
    drive_m(4'd1, 4'h1, 4'hf, 64'd0, 4'hf, 64'd0);
    step();
    check("col_R4", rf[4], 64'h20);

    // 4: stall / stall+bubble / bubble
    drive_m(4'd1, 4'h6, 4'h5, 64'h77, 4'hf, 64'd0);
    step();
    check("ld_dstE", W_dstE_o, 64'h5);
    drive_m(4'd1, 4'h3, 4'h6, 64'h99, 4'hf, 64'd0);
    W_stall_i = 1'b1;
    step();
    check("stall_dstE", W_dstE_o, 64'h5);
    check("stall_valE", W_valE_o, 64'h77);
    check("stall_icode", W_icode_o, 64'h6);
    W_bubble_i = 1'b1;
    step();
    check("stbub_dstE", W_dstE_o, 64'h5);
    check("stbub_icode", W_icode_o, 64'h6);
    W_stall_i = 1'b0;
    step();
    check("bub_icode", W_icode_o, 64'h1);
    check("bub_dstE", W_dstE_o, 64'hf);
    check("bub_dstM", W_dstM_o, 64'hf);
    check("bub_wr_e", wr_e_en_o, 64'd0);
    W_bubble_i = 1'b0;

    // Two more real instructions, then a NOP
    drive_m(4'd1, 4'h6, 4'h7, 64'h1234, 4'hf, 64'd0);
    step();
    drive_m(4'd1, 4'h6, 4'h8, 64'habcd, 4'hf, 64'd0);
    step();
    drive_m(4'd1, 4'h1, 4'hf, 64'd0, 4'hf, 64'd0);
    step();
    check("R7", rf[7], 64'h1234);
    check("R8", rf[8], 64'habcd);
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = 64'd5;
`else
    exp_cnt = 64'd0;
`endif
    check("retire_cnt", retire_cnt_o, exp_cnt);

    // 5: halt instruction carrying a destination that must not be written
    drive_m(4'd2, 4'h0, 4'ha, 64'hbad, 4'hf, 64'd0);
    step();
    check("hlt_icode", W_icode_o, 64'h0);
    check("hlt_wr_e", wr_e_en_o, 64'd0);
    check("hlt_wr_m", wr_m_en_o, 64'd0);
    check("hlt_stat_w", stat_o, 64'd2);
    check("hlt_not_yet", halted_o, 64'd0);
    step();
    check("hlt_halted", halted_o, 64'd1);
    check("hlt_stat", stat_o, 64'd2);
    drive_m(4'd1, 4'h6, 4'h9, 64'hdead, 4'hf, 64'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("frz_halted", halted_o, 64'd1);
      check("frz_dstE", W_dstE_o, 64'ha);
      check("frz_wr_e", wr_e_en_o, 64'd0);
      check("frz_stat", stat_o, 64'd2);
    end
    check("frz_RA", rf[10], 64'd0);
    check("frz_R9", rf[9], 64'd0);
    check("frz_cnt", retire_cnt_o, exp_cnt);

    rst_i = 1'b1;
    step();
    check("rst2_stat", stat_o, 64'd1);
    check("rst2_halted", halted_o, 64'd0);
    check("rst2_icode", W_icode_o, 64'h1);
    check("rst2_cnt", retire_cnt_o, 64'd0);
    rst_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
